inst_fetch_unit: RTL and testbench

//   Instruction fetch stage of the RV32I core; sits directly upstream of decode/immediate generation.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_queue.sv | 55 +++++
 rtl/inst_fetch_unit.sv | 137 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: NOP encoding, reset PC, fetch FSM states and queue entry layout.
package cpu_pkg;

  localparam logic [31:0] RV_NOP           = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO between imem responses and decode; flush empties it and wins over push.
module fetch_queue #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW:0]    FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// RV32I fetch stage: credit-limited in-order imem requests, response queue toward decode,
// redirect flush with stale-response dropping, and fault markers for imem errors / misaligned PCs.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic                  id_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int EW = $bits(fetch_entry_t);

  fetch_state_e          r_state;
  fetch_state_e          w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_rsp_pc;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_drop;
  logic                  r_mis_pend;

  logic [CW-1:0]         w_out_next;
  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_credit;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_keep;
  logic                  w_push_fault;
  logic                  w_push;
  logic                  w_misaligned;
  fetch_entry_t          w_push_entry;
  fetch_entry_t          w_head;
  logic [EW-1:0]         w_head_raw;

  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign w_pop        = id_valid && id_ready;

  // The entry decode takes this cycle frees its slot, so it is returned as credit
  // immediately; this keeps a depth-2 queue streaming one word per cycle at 1-cycle imem latency.
  assign w_credit = (SW'(w_count) + SW'(r_outstanding) - SW'(w_pop)) < SW'(FIFO_DEPTH);

  assign imem_req_valid = (r_state == FETCH) && !rst && w_credit && !(w_full && !w_pop);
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_out_next     = r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);

  assign w_keep       = imem_rsp_valid && !redirect_valid && (r_drop == '0) && (r_state == FETCH);
  assign w_push_fault = r_mis_pend && (r_outstanding == '0) && !redirect_valid;
  assign w_push       = w_keep || w_push_fault;

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.inst  = w_push_fault ? RV_NOP : 32'(imem_rsp_data);
    w_push_entry.pc    = 32'(r_rsp_pc);
    w_push_entry.fault = w_push_fault || imem_rsp_err;
  end

  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = w_misaligned ? HALT : FETCH;
    end else if (w_push && w_push_entry.fault) begin
      w_state_next = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_mis_pend    <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        r_drop     <= w_out_next;
        r_pc       <= redirect_pc;
        r_rsp_pc   <= redirect_pc;
        r_mis_pend <= w_misaligned;
      end else begin
        if (w_accept)                        r_pc     <= r_pc + ADDR_WIDTH'(4);
        if (imem_rsp_valid && r_drop != '0)  r_drop   <= r_drop - CW'(1);
        if (w_keep)                          r_rsp_pc <= r_rsp_pc + ADDR_WIDTH'(4);
        if (w_push_fault)                    r_mis_pend <= 1'b0;
      end
    end
  end

  fetch_queue #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_data  (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head   = fetch_entry_t'(w_head_raw);
  assign id_valid = !w_empty;
  assign id_fault = id_valid && w_head.fault;
  assign id_inst  = (id_valid && !w_head.fault) ? DATA_WIDTH'(w_head.inst) : DATA_WIDTH'(RV_NOP);
  assign id_pc    = id_valid ? ADDR_WIDTH'(w_head.pc) : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with an in-order, variable-latency imem model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        imem_rsp_err   = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_fault;

  inst_fetch_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_fault       (id_fault)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hDEAD_0000;

  // imem model: word returned is addr ^ KEY, err on err_addr when enabled
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  int          lat      = 1;
  logic        err_en   = 1'b0;
  logic [31:0] err_addr = '0;
  int          cyc      = 0;
  int          nacc     = 0;

  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
    end else begin
      if (imem_rsp_valid) void'(pend.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{imem_req_addr, cyc + lat});
        nacc++;
      end
    end
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend[0].addr ^ KEY;
      imem_rsp_err   = err_en && (pend[0].addr == err_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
    end
  end

  // log of every word decode consumed
  logic [31:0] lpc[$];
  logic [31:0] linst[$];
  logic        lflt[$];

  always @(posedge clk) begin
    if (!rst && id_valid && id_ready) begin
      lpc.push_back(id_pc);
      linst.push_back(id_inst);
      lflt.push_back(id_fault);
    end
  end

  int total = 0;
  int bad   = 0;
  int lbase = 0;
  int abase = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] lp(input int i);
    return (lbase + i < lpc.size()) ? lpc[lbase + i] : 'x;
  endfunction

  function automatic logic [31:0] li(input int i);
    return (lbase + i < linst.size()) ? linst[lbase + i] : 'x;
  endfunction

  function automatic logic lf(input int i);
    return (lbase + i < lflt.size()) ? lflt[lbase + i] : 1'bx;
  endfunction

  task automatic wait_log(input int n, input int bound, input string tag);
    int k;
    k = 0;
    while ((lpc.size() - lbase) < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'((lpc.size() - lbase) >= n), 32'd1);
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int k;

    // reset state
    cycles(3);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_id_valid",  32'(id_valid), 32'd0);
    chk("rst_id_inst",   id_inst, NOP);
    chk("rst_id_pc",     id_pc, 32'h0);
    chk("rst_id_fault",  32'(id_fault), 32'd0);

    // straight line, 1-cycle imem; release cycle is cycle 0, so the third cycle is index 2
    rst = 1'b0;
    #1;
    chk("rel_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rel_req_addr",  imem_req_addr, 32'h0);
    k = 0;
    while (!id_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("first_valid_cycle", 32'(k), 32'd2);
    chk("sl_pc0",   id_pc, 32'h0);
    chk("sl_inst0", id_inst, 32'h0 ^ KEY);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("sl_valid", 32'(id_valid), 32'd1);
      chk("sl_pc",    id_pc, 32'(4 * i));
    end

    // back-pressure: head pc 0xC stalls, queue fills, no loss on release
    id_ready = 1'b0;
    abase    = nacc;
    cycles(10);
    chk("bp_reqs_le2",  32'((nacc - abase) <= 2), 32'd1);
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_head_pc",   id_pc, 32'hC);
    lbase    = lpc.size();
    id_ready = 1'b1;
    wait_log(6, 40, "bp_drain_timeout");
    for (int i = 0; i < 6; i++) chk("bp_order", lp(i), 32'(32'hC + 4 * i));

    // redirect with two responses in flight on a 3-cycle imem
    lat = 3;
    k   = 0;
    while (pend.size() != 2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("rd1_two_inflight", 32'(pend.size()), 32'd2);
    redir(32'h100);
    lbase = lpc.size();
    wait_log(2, 40, "rd1_timeout");
    chk("rd1_pc0",   lp(0), 32'h100);
    chk("rd1_inst0", li(0), 32'h100 ^ KEY);
    chk("rd1_pc1",   lp(1), 32'h104);

    // redirect coincident with a request accept and a response
    lat = 1;
    cycles(8);
    k = 0;
    while (!(imem_req_valid && imem_rsp_valid && pend.size() == 1) && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("co_found", 32'(imem_req_valid && imem_rsp_valid), 32'd1);
    redir(32'h200);
    lbase = lpc.size();
    chk("co_r1_id_valid", 32'(id_valid), 32'd0);
    chk("co_r1_req_addr", imem_req_addr, 32'h200);
    @(negedge clk);
    chk("co_r2_id_valid", 32'(id_valid), 32'd0);
    @(negedge clk);
    chk("co_r3_id_valid", 32'(id_valid), 32'd1);
    chk("co_r3_id_pc",    id_pc, 32'h200);
    wait_log(2, 20, "co_timeout");
    chk("co_pc1", lp(1), 32'h204);

    // access fault on pc 0x8
    err_addr = 32'h8;
    err_en   = 1'b1;
    redir(32'h0);
    lbase = lpc.size();
    wait_log(3, 30, "err_timeout");
    chk("err_pc0",    lp(0), 32'h0);
    chk("err_pc1",    lp(1), 32'h4);
    chk("err_flt1",   32'(lf(1)), 32'd0);
    chk("err_pc2",    lp(2), 32'h8);
    chk("err_flt2",   32'(lf(2)), 32'd1);
    chk("err_inst2",  li(2), NOP);
    abase = nacc;
    cycles(10);
    chk("err_no_reqs",   32'(nacc - abase), 32'd0);
    chk("err_req_valid", 32'(imem_req_valid), 32'd0);
    chk("err_no_more",   32'(lpc.size() - lbase), 32'd3);

    // aligned redirect leaves HALT
    redir(32'h20);
    lbase = lpc.size();
    wait_log(1, 20, "r20_timeout");
    chk("r20_pc",  lp(0), 32'h20);
    chk("r20_flt", 32'(lf(0)), 32'd0);

    // misaligned redirect: no fetch, fault marker carrying the target
    cycles(3);
    redir(32'h102);
    abase = nacc;
    lbase = lpc.size();
    chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
    wait_log(1, 20, "mis_timeout");
    chk("mis_pc",   lp(0), 32'h102);
    chk("mis_flt",  32'(lf(0)), 32'd1);
    chk("mis_inst", li(0), NOP);
    cycles(5);
    chk("mis_no_reqs", 32'(nacc - abase), 32'd0);
    chk("mis_no_more", 32'(lpc.size() - lbase), 32'd1);

    // reset pulse mid-stream refetches from 0x0
    err_en = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    chk("rst2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst2_id_valid",  32'(id_valid), 32'd0);
    rst   = 1'b0;
    lbase = lpc.size();
    #1;
    chk("rst2_req_valid_rel", 32'(imem_req_valid), 32'd1);
    chk("rst2_req_addr",      imem_req_addr, 32'h0);
    wait_log(2, 20, "rst2_timeout");
    chk("rst2_pc0",  lp(0), 32'h0);
    chk("rst2_pc1",  lp(1), 32'h4);
    chk("rst2_inst1", li(1), 32'h4 ^ KEY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
